adder_arbiter: RTL
==================

# adder_arbiter

Round-robin arbiter that shares a single `adder` instance among `NREQ` requesters in the single-cycle datapath. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, registers the operands and the sum, and returns the result with a one-hot response valid held until acknowledged. It lets address-generation and auxiliary units reuse one adder instead of instantiating one each.

## Interface
- `WIDTH`, 8: operand and result width, passed to the internal `adder`.
- `NREQ`, 4: number of requesters, 2..8.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input NREQ: bit i means requester i offers operands.
- `req_a` input NREQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` input NREQ*WIDTH: operand B, same packing as `req_a`.
- `req_ready` output NREQ: one-hot accept strobe; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` output NREQ: one-hot; bit i means `rsp_y` belongs to requester i.
- `rsp_y` output WIDTH: registered sum.
- `rsp_ready` input 1: consumer acknowledges the response.
- `busy` output 1: high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit searching upward from `rr_ptr` with wrap-around.
  - `req_ready[winner]` = 1 in that same cycle (combinational from `req_valid` and `rr_ptr`).
  - Operands are latched into `a_q`/`b_q`, the winner index goes to `id_q`, `rr_ptr` ← (winner+1) mod NREQ, and the FSM goes to EXEC.
  - If no request: stay in IDLE, all `req_ready` = 0.
- EXEC:
  - `adder` computes `a_q + b_q`; the result is registered into `rsp_y`.
  - Next state is RESP, unconditionally.
- RESP:
  - `rsp_valid[id_q]` = 1; `rsp_y` and `rsp_valid` are held stable.
  - When `rsp_ready` = 1: go to IDLE, and `rsp_valid` drops on the next cycle.
- Handshake rules:
  - `req_ready` is 0 outside IDLE.
  - Requesters hold `req_valid` and operands stable until accepted; a requester that drops valid before acceptance is simply not granted.
  - Non-winning requesters see `req_ready` = 0 and must keep waiting.
- Arithmetic: unsigned modulo 2^WIDTH; carry-out is discarded, identical to `adder`.
- Fairness: `rr_ptr` advances only on accept. With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- Simultaneous events:
  - `rsp_ready` in RESP together with new `req_valid`: no accept in that cycle. Accept happens in the following IDLE cycle using the already-advanced `rr_ptr`.
  - `rsp_ready` outside RESP is ignored.
- Reset, including mid-operation: state ← IDLE, `rr_ptr` ← 0, `a_q`/`b_q`/`id_q` ← 0, `rsp_y` ← 0, `rsp_valid` ← 0. Any in-flight operation is dropped and produces no response.
- Reset values of outputs: `req_ready` = 0 (IDLE with no valid), `rsp_valid` = 0, `rsp_y` = 0, `busy` = 0.

## Timing
- Accept at cycle T, meaning the `req_valid & req_ready` edge at the end of T.
- EXEC in T+1.
- `rsp_valid` and `rsp_y` become visible in T+2.
- With `rsp_ready` held at 1: RESP lasts one cycle, IDLE is at T+3, and the next accept is at T+3. Peak throughput is one operation per 3 cycles.
- Each cycle of `rsp_ready` = 0 in RESP extends the response by one cycle.
- No combinational path from `rsp_ready` to any output. The only combinational output path is `req_valid` → `req_ready`.

## Test plan
1. Reset held 2 cycles, then released with no requests -> `req_ready` = 0, `rsp_valid` = 0, `rsp_y` = 0x00, `busy` = 0, FSM stays IDLE.
2. Requester 1 valid at T with a=0x12, b=0x34; `rsp_ready` = 1 -> `req_ready` = 0b0010 at T; `rsp_valid` = 0b0010 and `rsp_y` = 0x46 at T+2; `rsp_valid` = 0 at T+3.
3. Requester 3 with a=0xFF, b=0x02 -> `rsp_y` = 0x01 (wrap), `rsp_valid` = 0b1000.
4. All four `req_valid` continuously high, `rsp_ready` = 1 -> grants in order 0,1,2,3,0, exactly 3 cycles apart; each response tagged with the matching one-hot bit.
5. Response with `rsp_ready` = 0 for 5 cycles while requester 2 is valid -> `rsp_y`/`rsp_valid` stable for all 5 cycles, `req_ready` = 0 throughout. Requester 2 is granted in the first IDLE cycle after `rsp_ready` is pulsed.
6. `reset` asserted during EXEC of a requester-2 operation -> no `rsp_valid` ever appears for it. With requesters 0 and 2 then valid, the first grant goes to requester 0 (`rr_ptr` = 0).

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters.
// Flow per operation: accept in IDLE, add in EXEC, hold result in RESP.

module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    // Unsigned modulo 2^WIDTH; carry-out is intentionally dropped.
    assign y = a + b;
endmodule

module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_y,
    input  logic                  rsp_ready,
    output logic                  busy
);
    // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
    // a response is held in rsp_valid/rsp_y until a cycle with rsp_ready high.
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr, id_q, winner;
    logic              found, accept;
    logic [WIDTH-1:0]  a_q, b_q, sum;

    always_comb begin : win_search
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept) req_ready[winner] = 1'b1;
        if (state_q == RESP) rsp_valid[id_q] = 1'b1;
        busy = (state_q != IDLE);
    end

    adder #(.WIDTH(WIDTH)) u_adder (
        .a (a_q),
        .b (b_q),
        .y (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rsp_y  <= '0;
        end else begin
            if (accept) begin
                a_q    <= req_a[winner*WIDTH +: WIDTH];
                b_q    <= req_b[winner*WIDTH +: WIDTH];
                id_q   <= winner;
                rr_ptr <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
            end
            if (state_q == EXEC) rsp_y <= sum;
        end
    end
endmodule
